updown_counter_param: RTL and testbench

- Parametrised up/down counter; next generation of the team's fixed 4-bit up/down counter.
- Adds:
  - configurable width and modulus (terminal value)
  - count enable and synchronous parallel load
  - per-cycle wrap/saturate mode select
  - registered boundary pulse and sticky boundary flag
- Used as a generic event/sequence counter in the lab designs, e.g. a decade counter feeding 7-segment display logic.

---
 rtl/updown_counter_pkg.sv | 18 +
 rtl/updown_counter_param_prescaler.sv | 41 ++++
 rtl/updown_counter_param.sv | 132 +++++++++++++
 tb/tb_updown_counter_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared encodings for the parametrised up/down counter: direction and
// boundary-mode select values, plus the per-edge action type.
package updown_counter_pkg;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  localparam logic SAT_ON    = 1'b1;
  localparam logic SAT_WRAP  = 1'b0;

  // What the counter does on a given clock edge, after reset is excluded.
  typedef enum logic [1:0] {
    STEP_HOLD  = 2'd0,
    STEP_LOAD  = 2'd1,
    STEP_COUNT = 2'd2
  } step_e;

endpackage

// File: rtl/updown_counter_param_prescaler.sv
// Prescaler for updown_counter_param; only compiled when UDC_PRESCALER_EN is
// defined. Emits a tick on every PRESCALE-th enabled cycle.
`ifdef UDC_PRESCALER_EN
module udc_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en_in,
  output logic tick_out
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // clear (parallel load in the parent) restarts the divide sequence
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en_in) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_out = en_in && (count_q == LAST);

endmodule
`endif

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate select, boundary pulse
// and sticky flag. Optional prescaler enabled by defining UDC_PRESCALER_EN.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] out,
  output logic             bnd,
  output logic             ovf_flag
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_OUT = WIDTH'(MAX_VAL);

  if (WIDTH < 1 || MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1 || PRESCALE < 1) begin : gBadParams
    $error("updown_counter_param: illegal WIDTH/MAX_VAL/PRESCALE combination");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             bnd_q;
  logic             bnd_d;
  logic             flag_q;
  logic             flag_d;

  logic             countTick;
  logic [WIDTH:0]   countExt;
  logic [WIDTH:0]   loadExt;
  logic [WIDTH:0]   upExt;
  logic [WIDTH:0]   downExt;
  logic             atMax;
  logic             atZero;
  logic             boundary;
  step_e            step;

`ifdef UDC_PRESCALER_EN
  udc_prescaler #(
    .PRESCALE (PRESCALE)
  ) uPrescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (load),
    .en_in    (en),
    .tick_out (countTick)
  );
`else
  assign countTick = en;
`endif

  // Limit checks use MAX_VAL so non-power-of-two moduli wrap correctly
  assign countExt = {1'b0, count_q};
  assign loadExt  = {1'b0, load_val};
  assign upExt    = countExt + 1'b1;
  assign downExt  = countExt - 1'b1;
  assign atMax    = (countExt == MAX_EXT);
  assign atZero   = (countExt == '0);

  always_comb begin
    step = STEP_HOLD;
    if (load) begin
      step = STEP_LOAD;
    end else if (countTick) begin
      step = STEP_COUNT;
    end
  end

  always_comb begin
    count_d  = count_q;
    boundary = 1'b0;
    unique case (step)
      STEP_LOAD: begin
        count_d = (loadExt > MAX_EXT) ? MAX_OUT : load_val;
      end
      STEP_COUNT: begin
        unique case (mode)
          MODE_UP: begin
            if (atMax) begin
              boundary = 1'b1;
              count_d  = (sat == SAT_WRAP) ? '0 : MAX_OUT;
            end else begin
              count_d  = WIDTH'(upExt);
            end
          end
          MODE_DOWN: begin
            if (atZero) begin
              boundary = 1'b1;
              count_d  = (sat == SAT_ON) ? '0 : MAX_OUT;
            end else begin
              count_d  = WIDTH'(downExt);
            end
          end
          default: count_d = count_q;
        endcase
      end
      default: count_d = count_q;
    endcase
  end

  // A boundary event beats a coincident clr_flag
  always_comb begin
    bnd_d  = boundary;
    flag_d = boundary | (flag_q & ~clr_flag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      bnd_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      bnd_q   <= bnd_d;
      flag_q  <= flag_d;
    end
  end

  assign out      = count_q;
  assign bnd      = bnd_q;
  assign ovf_flag = flag_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param (WIDTH=4, MAX_VAL=9, default
// build): directed scenarios with literal expectations, then random traffic.
module tb_updown_counter_param;

  localparam int WIDTH   = 4;
  localparam int MAX_VAL = 9;

  logic             clk;
  logic             rst;
  logic             en;
  logic             mode;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_flag;
  logic [WIDTH-1:0] out;
  logic             bnd;
  logic             ovf_flag;

  int compared   = 0;
  int mismatched = 0;
  bit checkOn    = 1'b0;

  int modelCount = 0;
  int modelBnd   = 0;
  int modelFlag  = 0;

  updown_counter_param #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .PRESCALE (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .clr_flag (clr_flag),
    .out      (out),
    .bnd      (bnd),
    .ovf_flag (ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: modular / clamped arithmetic on plain integers
  always @(posedge clk) begin
    int boundary;
    int clr;
    clr = int'(clr_flag);
    if (rst) begin
      modelCount = 0;
      modelBnd   = 0;
      modelFlag  = 0;
    end else if (load) begin
      modelCount = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
      modelBnd   = 0;
      modelFlag  = modelFlag & ~clr & 1;
    end else if (en) begin
      if (mode) begin
        boundary   = (modelCount == MAX_VAL) ? 1 : 0;
        modelCount = sat ? ((modelCount + 1 > MAX_VAL) ? MAX_VAL : modelCount + 1)
                         : (modelCount + 1) % (MAX_VAL + 1);
      end else begin
        boundary   = (modelCount == 0) ? 1 : 0;
        modelCount = sat ? ((modelCount - 1 < 0) ? 0 : modelCount - 1)
                         : (modelCount + MAX_VAL) % (MAX_VAL + 1);
      end
      modelBnd  = boundary;
      modelFlag = boundary ? 1 : (modelFlag & ~clr & 1);
    end else begin
      modelBnd  = 0;
      modelFlag = modelFlag & ~clr & 1;
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      compared++;
      if (int'(out) != modelCount) begin
        mismatched++;
        $display("[TB] FAIL model_out t=%0t actual=%0d required=%0d", $time, out, modelCount);
      end
      compared++;
      if (int'(bnd) != modelBnd) begin
        mismatched++;
        $display("[TB] FAIL model_bnd t=%0t actual=%0d required=%0d", $time, bnd, modelBnd);
      end
      compared++;
      if (int'(ovf_flag) != modelFlag) begin
        mismatched++;
        $display("[TB] FAIL model_flag t=%0t actual=%0d required=%0d", $time, ovf_flag, modelFlag);
      end
    end
  end

  // Drive one edge's inputs, then return shortly after that edge
  task automatic applyStimulus(input logic r, input logic e, input logic m, input logic s,
                               input logic l, input logic [WIDTH-1:0] lv, input logic c);
    rst      = r;
    en       = e;
    mode     = m;
    sat      = s;
    load     = l;
    load_val = lv;
    clr_flag = c;
    @(posedge clk);
    #1;
  endtask

  // Literal expectations, checked on both the DUT and the reference model
  task automatic checkOutput(input string name, input int expOut, input int expBnd, input int expFlag);
    compared++;
    if (int'(out) != expOut || int'(bnd) != expBnd || int'(ovf_flag) != expFlag) begin
      mismatched++;
      $display("[TB] FAIL %s actual out=%0d bnd=%0d flag=%0d required out=%0d bnd=%0d flag=%0d",
               name, out, bnd, ovf_flag, expOut, expBnd, expFlag);
    end
    compared++;
    if (modelCount != expOut || modelBnd != expBnd || modelFlag != expFlag) begin
      mismatched++;
      $display("[TB] FAIL %s_model actual out=%0d bnd=%0d flag=%0d required out=%0d bnd=%0d flag=%0d",
               name, modelCount, modelBnd, modelFlag, expOut, expBnd, expFlag);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b1; sat = 1'b0;
    load = 1'b0; load_val = '0; clr_flag = 1'b0;

    applyStimulus(1, 0, 1, 0, 0, 4'd0, 0);
    checkOn = 1'b1;
    applyStimulus(1, 0, 1, 0, 0, 4'd0, 0);
    checkOutput("reset", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 4'd0, 0);
      checkOutput("idle_hold", 0, 0, 0);
    end

    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 4'd0, 0);
      checkOutput("up_wrap", i % 10, (i == 10) ? 1 : 0, (i == 10) ? 1 : 0);
    end

    applyStimulus(0, 0, 1, 0, 1, 4'd1, 0);
    checkOutput("load_one", 1, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 4'd0, 0);
      checkOutput("down_sat", 0, (i >= 2) ? 1 : 0, 1);
    end

    applyStimulus(0, 1, 1, 0, 1, 4'hF, 0);
    checkOutput("load_clamp", 9, 0, 1);
    applyStimulus(1, 1, 1, 0, 1, 4'hF, 0);
    checkOutput("rst_over_load", 0, 0, 0);

    applyStimulus(0, 1, 0, 0, 0, 4'd0, 0);
    checkOutput("down_wrap", 9, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 1);
    checkOutput("clr_alone", 9, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4'd0, 1);
    checkOutput("clr_vs_wrap", 0, 1, 1);
    applyStimulus(0, 0, 1, 0, 0, 4'd0, 0);
    checkOutput("flag_sticky", 0, 0, 1);

    applyStimulus(0, 0, 1, 1, 1, 4'd8, 1);
    checkOutput("load_clr", 8, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 4'd0, 0);
      checkOutput("up_sat", 9, (i >= 2) ? 1 : 0, (i >= 2) ? 1 : 0);
    end

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom),
                    1'($urandom),
                    ($urandom_range(0, 9) == 0),
                    4'($urandom),
                    ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
